// File: rtl/fetch_issue_unit.sv
// Front end of the AsyncARM core: fetches ROM words over a toggle handshake, screens their
// condition codes against CPSR, and issues survivors to decode. Define COND_EVAL_EN to enable condition screening.
module fetch_issue_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] RESET_CPSR = 32'h0000_00D3
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] mem_addr,
  output logic        mem_trig,
  input  logic [31:0] mem_data,
  input  logic        mem_ready,
  input  logic        trig_in,
  output logic        ready_out,
  output logic [31:0] data_out,
  input  logic        pc_we,
  input  logic [31:0] pc_wdata,
  input  logic        cpsr_we,
  input  logic [31:0] cpsr_wdata,
  output logic [31:0] pc_out,
  output logic [31:0] cpsr_out
);

  typedef enum logic [1:0] {FETCH, WAIT, CHECK, HOLD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] cpsr;
  logic [31:0] word;
  logic        trig_sampled;
  logic        discard;
  logic        check_pass;

`ifdef COND_EVAL_EN
  // Pairs of ARM conditions share a base test; odd codes are the inverse. 4'hE and 4'hF both mean always.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, base;
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    case (cond[3:1])
      3'd0:    base = z;
      3'd1:    base = c;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = c & ~z;
      3'd5:    base = (n == v);
      3'd6:    base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    cond_pass = (cond[3:1] == 3'd7) ? 1'b1 : (base ^ cond[0]);
  endfunction

  assign check_pass = cond_pass(word[31:28], cpsr[31:28]);
`else
  assign check_pass = 1'b1;
`endif

  assign pc_out   = pc;
  assign cpsr_out = cpsr;

  // A redirect while a request is outstanding must still absorb that response, so it is marked for discard.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      cpsr         <= RESET_CPSR;
      word         <= 32'h0;
      mem_addr     <= 32'h0;
      mem_trig     <= 1'b0;
      ready_out    <= 1'b0;
      data_out     <= 32'h0;
      trig_sampled <= 1'b0;
      discard      <= 1'b0;
    end else begin
      if (cpsr_we)
        cpsr <= cpsr_wdata;
      if (pc_we) begin
        pc        <= pc_wdata & ~32'h3;
        ready_out <= 1'b0;
        if (state == WAIT && mem_ready != mem_trig) begin
          discard <= 1'b1;
        end else begin
          discard <= 1'b0;
          state   <= FETCH;
        end
      end else begin
        case (state)
          FETCH: begin
            mem_addr <= pc;
            mem_trig <= ~mem_trig;
            state    <= WAIT;
          end
          WAIT: begin
            if (mem_ready == mem_trig) begin
              if (discard) begin
                discard <= 1'b0;
                state   <= FETCH;
              end else begin
                word  <= mem_data;
                pc    <= pc + 32'd4;
                state <= CHECK;
              end
            end
          end
          CHECK: begin
            if (check_pass) begin
              data_out  <= word;
              ready_out <= 1'b1;
              state     <= HOLD;
            end else begin
              state <= FETCH;
            end
          end
          HOLD: begin
            if (trig_in != trig_sampled) begin
              trig_sampled <= trig_in;
              ready_out    <= 1'b0;
              state        <= FETCH;
            end
          end
          default: state <= FETCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_issue_unit.sv
// Self-checking bench for fetch_issue_unit: a random-latency ROM, a transaction-level model of
// which addresses get requested and which words get issued, plus directed pinned cases.
module tb_fetch_issue_unit;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] RESET_CPSR = 32'h0000_00D3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] mem_addr;
  logic        mem_trig;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        trig_in = 1'b0;
  logic        ready_out;
  logic [31:0] data_out;
  logic        pc_we = 1'b0;
  logic [31:0] pc_wdata = 32'h0;
  logic        cpsr_we = 1'b0;
  logic [31:0] cpsr_wdata = 32'h0;
  logic [31:0] pc_out;
  logic [31:0] cpsr_out;

  fetch_issue_unit #(.RESET_PC(RESET_PC), .RESET_CPSR(RESET_CPSR)) dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_trig(mem_trig), .mem_data(mem_data),
    .mem_ready(mem_ready), .trig_in(trig_in), .ready_out(ready_out), .data_out(data_out),
    .pc_we(pc_we), .pc_wdata(pc_wdata), .cpsr_we(cpsr_we), .cpsr_wdata(cpsr_wdata),
    .pc_out(pc_out), .cpsr_out(cpsr_out)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int resp_cyc = 0;
  int cons_cyc = 0;
  bit cons_pending = 1'b0;

  logic [31:0] rom [256];

  // Model state: address of the next request, the request in flight and whether its word should issue.
  logic [31:0] m_cpsr = RESET_CPSR;
  logic [31:0] m_exp_addr = RESET_PC;
  logic [31:0] m_req_addr = 32'h0;
  logic [31:0] m_exp_word = 32'h0;
  bit          m_expect_issue = 1'b0;
  bit          m_issued = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic bit model_pass(input logic [3:0] cond, input logic [3:0] flags);
`ifdef COND_EVAL_EN
    bit n, z, c, v;
    n = flags[3]; z = flags[2]; c = flags[1]; v = flags[0];
    case (cond)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return c && !z;
      4'h9: return !c || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      default: return 1'b1;
    endcase
`else
    return (cond == flags) || 1'b1;
`endif
  endfunction

  // ROM: notices a new request on the falling edge and answers after 0..3 further falling edges.
  initial begin : rom_proc
    bit pend;
    int lat;
    logic [31:0] a;
    pend = 1'b0;
    lat = 0;
    a = 32'h0;
    mem_ready = 1'b0;
    mem_data = 32'h0;
    forever begin
      @(negedge clk);
      if (reset) begin
        mem_ready = 1'b0;
        pend = 1'b0;
        mem_data = $urandom;
      end else begin
        if (!pend && mem_trig != mem_ready) begin
          pend = 1'b1;
          a = mem_addr;
          lat = $urandom_range(0, 3);
        end
        if (pend) begin
          if (lat == 0) begin
            mem_data = rom[a[9:2]];
            mem_ready = mem_trig;
            pend = 1'b0;
            resp_cyc = cyc;
          end else begin
            lat--;
            mem_data = $urandom;
          end
        end
      end
    end
  end

  // Compare process: sampled 1 time unit after each rising edge.
  initial begin : compare_proc
    logic prev_trig, prev_ready;
    prev_trig = 1'b0;
    prev_ready = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!reset) begin
        checkOutput("cpsr_out", cpsr_out, m_cpsr);
        if (mem_trig != prev_trig) begin
          if (m_expect_issue && !m_issued) checkOutput("skipped_issue", 32'(m_issued), 32'd1);
          if (cons_pending) begin
            checkOutput("consume_latency", 32'(cyc - cons_cyc), 32'd2);
            cons_pending = 1'b0;
          end
          checkOutput("mem_addr", mem_addr, m_exp_addr);
          m_req_addr = m_exp_addr;
          m_exp_addr = m_exp_addr + 32'd4;
          m_exp_word = rom[m_req_addr[9:2]];
          m_expect_issue = model_pass(m_exp_word[31:28], m_cpsr[31:28]);
          m_issued = 1'b0;
        end else if (mem_trig != mem_ready) begin
          checkOutput("mem_addr_hold", mem_addr, m_req_addr);
        end
        if (ready_out && !prev_ready) begin
          checkOutput("unexpected_issue", 32'(m_expect_issue), 32'd1);
          checkOutput("issue_pc", pc_out, m_req_addr + 32'd4);
          checkOutput("issue_latency", 32'(cyc - resp_cyc), 32'd2);
          m_issued = 1'b1;
        end
        if (ready_out) checkOutput("data_out", data_out, m_exp_word);
        if (cons_pending && cyc == cons_cyc + 1) checkOutput("ready_drop", 32'(ready_out), 32'd0);
      end
      prev_trig = mem_trig;
      prev_ready = ready_out;
    end
  end

  task automatic waitReady(input string name);
    int n;
    n = 0;
    while (!ready_out && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!ready_out) checkOutput({name, "_timeout"}, 32'(ready_out), 32'd1);
  endtask

  task automatic waitRequest(input string name);
    logic t;
    int n;
    t = mem_trig;
    n = 0;
    while (mem_trig == t && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (mem_trig == t) checkOutput({name, "_timeout"}, 32'(mem_trig), 32'(~t));
  endtask

  task automatic consume();
    trig_in = ~trig_in;
    cons_cyc = cyc;
    cons_pending = 1'b1;
    @(negedge clk);
  endtask

  task automatic redirect(input logic [31:0] target);
    pc_we = 1'b1;
    pc_wdata = target;
    m_exp_addr = target & ~32'h3;
    m_expect_issue = 1'b0;
    @(negedge clk);
    pc_we = 1'b0;
    checkOutput("redirect_pc", pc_out, target & ~32'h3);
    checkOutput("redirect_ready", 32'(ready_out), 32'd0);
  endtask

  task automatic writeCpsr(input logic [31:0] v);
    cpsr_we = 1'b1;
    cpsr_wdata = v;
    m_cpsr = v;
    @(negedge clk);
    cpsr_we = 1'b0;
  endtask

  task automatic assertReset();
    reset = 1'b1;
    trig_in = 1'b0;
    m_cpsr = RESET_CPSR;
    m_exp_addr = RESET_PC;
    m_expect_issue = 1'b0;
    m_issued = 1'b0;
    cons_pending = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_ready", 32'(ready_out), 32'd0);
    checkOutput("reset_pc", pc_out, RESET_PC);
    checkOutput("reset_cpsr", cpsr_out, RESET_CPSR);
    checkOutput("reset_trig", 32'(mem_trig), 32'd0);
  endtask

  task automatic releaseReset();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("first_request", 32'(mem_trig), 32'd1);
  endtask

  // One random action taken from HOLD: consume, redirect from HOLD or WAIT, or a CPSR write.
  task automatic applyStimulus(input int action);
    logic [31:0] v;
    v = $urandom;
    case (action)
      0: redirect(v);
      1: writeCpsr({v[31:28], 28'h00000D3});
      2: begin
        consume();
        waitRequest("rand_req");
        redirect(v);
      end
      default: consume();
    endcase
    waitReady("rand_ready");
  endtask

  initial begin : main
    logic [31:0] w;
    for (int i = 0; i < 256; i++) rom[i] = 32'hE000_0000 | 32'(i);
    rom[0]   = 32'hE3A0_0001;
    rom[1]   = 32'hE1A0_1002;
    rom[8]   = 32'h0A00_0000;
    rom[9]   = 32'hE281_1001;
    rom[16]  = 32'hE081_1002;
    rom[64]  = 32'hE3A0_2005;
    rom[255] = 32'hE3A0_30FF;

    assertReset();
    checkOutput("reset_data", data_out, 32'h0);
    releaseReset();
    checkOutput("first_addr", mem_addr, 32'h0);

    waitReady("t1");
    checkOutput("t1_data", data_out, 32'hE3A0_0001);
    checkOutput("t1_pc", pc_out, 32'h4);
    consume();
    waitReady("t2");
    checkOutput("t2_data", data_out, 32'hE1A0_1002);
    checkOutput("t2_pc", pc_out, 32'h8);

    redirect(32'h0000_0103);
    waitRequest("redir_req");
    checkOutput("redir_addr", mem_addr, 32'h0000_0100);
    waitReady("t3");
    checkOutput("t3_data", data_out, 32'hE3A0_2005);

    redirect(32'h0000_0022);
    waitReady("beq");
`ifdef COND_EVAL_EN
    checkOutput("beq_skip_data", data_out, 32'hE281_1001);
    checkOutput("beq_skip_pc", pc_out, 32'h28);
`else
    checkOutput("beq_issue_data", data_out, 32'h0A00_0000);
    checkOutput("beq_issue_pc", pc_out, 32'h24);
`endif

    redirect(32'hFFFF_FFFC);
    waitReady("wrap");
    checkOutput("wrap_data", data_out, 32'hE3A0_30FF);
    checkOutput("wrap_pc", pc_out, 32'h0);

    consume();
    waitRequest("wait_req");
    redirect(32'h0000_0040);
    waitReady("wait_redir");
    checkOutput("wait_redir_data", data_out, 32'hE081_1002);
    checkOutput("wait_redir_pc", pc_out, 32'h44);

    writeCpsr(32'h4000_00D3);
    checkOutput("cpsr_write", cpsr_out, 32'h4000_00D3);
    consume();
    waitReady("t4");
    checkOutput("t4_data", data_out, 32'hE000_0011);
    redirect(32'h0000_0020);
    waitReady("beq_take");
    checkOutput("beq_take_data", data_out, 32'h0A00_0000);
    checkOutput("beq_take_pc", pc_out, 32'h24);

    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      if ($urandom_range(0, 1) == 0) w[31:28] = 4'hE;
      rom[i] = w;
    end
    for (int k = 0; k < 250; k++) applyStimulus(int'($urandom_range(0, 9)));

    consume();
    waitRequest("late_req");
    assertReset();
    releaseReset();
    waitReady("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
